// File: rtl/game_turn_controller.sv
// Turn sequencer for the board-game datapath: takes card flips, strobes the
// compare (A) and move (B) operations, and advances turns on a miss, a
// timeout or a full board.
module game_turn_controller #(
   parameter int NUM_CARDS     = 12,
   parameter int CMP_LAT       = 2,
   parameter int REVEAL_CYCLES = 50_000_000,
   parameter int TURN_TIMEOUT  = 500_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  N,
   input  logic        flip_valid,
   input  logic [3:0]  flip_idx,
   input  logic        go,
   input  logic        W,
   output logic [3:0]  position_data,
   output logic        A,
   output logic        B,
   output logic        statecombo_next_turn,
   output logic [1:0]  cur_player,
   output logic [15:0] reveal_mask,
   output logic        flip_err,
   output logic        busy,
   output logic        game_over,
   output logic [1:0]  winner
);

   localparam int TMR_W   = $clog2(TURN_TIMEOUT + 1);
   localparam int CNT_MAX = (REVEAL_CYCLES > CMP_LAT) ? REVEAL_CYCLES : CMP_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TURN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CMP_LAST = CNT_W'(CMP_LAT - 1);
   localparam logic [CNT_W-1:0] REV_LAST = CNT_W'(REVEAL_CYCLES - 1);
   localparam logic [4:0]       NC       = 5'(NUM_CARDS);
   localparam logic [31:0]      FULL32   = (32'd1 << NUM_CARDS) - 32'd1;
   localparam logic [15:0]      FULL     = FULL32[15:0];

   typedef enum logic [3:0] {
      IDLE, WAIT_FLIP, COMPARE, CMP_WAIT, MOVE, CHECK_WIN, REVEAL, NEXT_TURN, GAME_OVER
   } state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         n_lat_q, n_lat_d;
   logic [3:0]         pos_q, pos_d;
   logic               a_q, a_d;
   logic               b_q, b_d;
   logic               nt_q, nt_d;
   logic [1:0]         cp_q, cp_d;
   logic [15:0]        mask_q, mask_d;
   logic               ferr_q, ferr_d;
   logic [1:0]         win_q, win_d;
   logic               flip_ok;
   logic               enter_nt;
   logic               enter_start;

   assign flip_ok = ({1'b0, flip_idx} < NC) && !mask_q[flip_idx];

   // Next-state and registered-output logic; strobes are raised on entry to
   // their state so each lines up with exactly one cycle of that state.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      cnt_d       = cnt_q;
      n_lat_d     = n_lat_q;
      pos_d       = pos_q;
      a_d         = 1'b0;
      b_d         = 1'b0;
      nt_d        = 1'b0;
      cp_d        = cp_q;
      mask_d      = mask_q;
      ferr_d      = 1'b0;
      win_d       = win_q;
      enter_nt    = 1'b0;
      enter_start = 1'b0;

      case (state_q)
         IDLE, GAME_OVER: begin
            if (start) enter_start = 1'b1;
         end
         WAIT_FLIP: begin
            if (flip_valid && flip_ok) begin
               pos_d            = flip_idx;
               mask_d[flip_idx] = 1'b1;
               timer_d          = '0;
               a_d              = 1'b1;
               state_d          = COMPARE;
            end else begin
               if (flip_valid) ferr_d = 1'b1;
               if (timer_q == TMR_LAST) enter_nt = 1'b1;
               else                     timer_d  = timer_q + TMR_W'(1);
            end
         end
         COMPARE: begin
            cnt_d   = '0;
            state_d = CMP_WAIT;
         end
         CMP_WAIT: begin
            if (cnt_q == CMP_LAST) begin
               if (go) begin
                  b_d     = 1'b1;
                  state_d = MOVE;
               end else begin
                  cnt_d   = '0;
                  state_d = REVEAL;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         MOVE: begin
            state_d = CHECK_WIN;
         end
         CHECK_WIN: begin
            if (W) begin
               win_d   = cp_q;
               state_d = GAME_OVER;
            end else if ((mask_q & FULL) == FULL) begin
               enter_nt = 1'b1;
            end else begin
               timer_d = '0;
               state_d = WAIT_FLIP;
            end
         end
         REVEAL: begin
            if (cnt_q == REV_LAST) enter_nt = 1'b1;
            else                   cnt_d    = cnt_q + CNT_W'(1);
         end
         NEXT_TURN: begin
            state_d = WAIT_FLIP;
         end
         default: state_d = IDLE;
      endcase

      // Turn hand-off: player, mask and timer change together with the pulse.
      if (enter_nt) begin
         nt_d    = 1'b1;
         cp_d    = (cp_q == n_lat_q) ? 2'd0 : cp_q + 2'd1;
         mask_d  = '0;
         timer_d = '0;
         state_d = NEXT_TURN;
      end

      // Fresh game, from IDLE or GAME_OVER.
      if (enter_start) begin
         n_lat_d = N;
         cp_d    = '0;
         mask_d  = '0;
         timer_d = '0;
         win_d   = '0;
         state_d = WAIT_FLIP;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         cnt_q   <= '0;
         n_lat_q <= '0;
         pos_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         nt_q    <= 1'b0;
         cp_q    <= '0;
         mask_q  <= '0;
         ferr_q  <= 1'b0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         n_lat_q <= n_lat_d;
         pos_q   <= pos_d;
         a_q     <= a_d;
         b_q     <= b_d;
         nt_q    <= nt_d;
         cp_q    <= cp_d;
         mask_q  <= mask_d;
         ferr_q  <= ferr_d;
         win_q   <= win_d;
      end
   end

   assign position_data        = pos_q;
   assign A                    = a_q;
   assign B                    = b_q;
   assign statecombo_next_turn = nt_q;
   assign cur_player           = cp_q;
   assign reveal_mask          = mask_q;
   assign flip_err             = ferr_q;
   assign winner               = win_q;
   assign game_over            = (state_q == GAME_OVER);
   assign busy                 = (state_q == COMPARE)   || (state_q == CMP_WAIT) ||
                                 (state_q == MOVE)      || (state_q == CHECK_WIN) ||
                                 (state_q == REVEAL)    || (state_q == NEXT_TURN);

endmodule

// File: tb/tb_game_turn_controller.sv
// Cycle-accurate vector bench for game_turn_controller with shortened
// reveal/timeout parameters. Vectors are built by small sequence helpers that
// track the expected player, mask, card and winner, then replayed one per clock.
module tb_game_turn_controller;

   logic        clk = 1'b0;
   logic        rst, start, flip_valid, go, W;
   logic [1:0]  N;
   logic [3:0]  flip_idx;
   logic [3:0]  position_data;
   logic        A, B, statecombo_next_turn, flip_err, busy, game_over;
   logic [1:0]  cur_player, winner;
   logic [15:0] reveal_mask;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   game_turn_controller #(
      .NUM_CARDS(12), .CMP_LAT(2), .REVEAL_CYCLES(4), .TURN_TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .N(N), .flip_valid(flip_valid),
      .flip_idx(flip_idx), .go(go), .W(W), .position_data(position_data),
      .A(A), .B(B), .statecombo_next_turn(statecombo_next_turn),
      .cur_player(cur_player), .reveal_mask(reveal_mask), .flip_err(flip_err),
      .busy(busy), .game_over(game_over), .winner(winner)
   );

   // One clock of stimulus plus the outputs expected right after that edge:
   // {position_data, A, B, next_turn, cur_player, reveal_mask, flip_err, busy, game_over, winner}
   typedef struct {
      logic        rst, start;
      logic [1:0]  n;
      logic        fv;
      logic [3:0]  fi;
      logic        go, w;
      logic [29:0] exp;
   } vec_t;

   vec_t vq[$];

   logic [3:0]  e_pd;
   logic [1:0]  e_cp, e_win, e_nl;
   logic [15:0] e_mask;
   logic        e_gov;

   task automatic push(input logic r, st, input logic [1:0] n, input logic fv,
                       input logic [3:0] fi, input logic g, w,
                       input logic a, b, nt, fe, bsy);
      vec_t v;
      v.rst = r; v.start = st; v.n = n; v.fv = fv; v.fi = fi; v.go = g; v.w = w;
      v.exp = {e_pd, a, b, nt, e_cp, e_mask, fe, bsy, e_gov, e_win};
      vq.push_back(v);
   endtask

   task automatic do_reset();
      e_pd = '0; e_cp = '0; e_mask = '0; e_gov = 1'b0; e_win = '0; e_nl = '0;
      push(0, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_start(input logic [1:0] n);
      e_cp = '0; e_mask = '0; e_gov = 1'b0; e_win = '0; e_nl = n;
      push(1, 1, n, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wf(input logic fv, input logic [3:0] fi, input logic fe);
      push(1, 0, 2'd0, fv, fi, 0, 0, 0, 0, 0, fe, 0);
   endtask

   task automatic busy_cyc(input logic noise);
      push(1, noise, noise ? 2'd3 : 2'd0, noise, 4'd0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic next_turn();
      e_cp   = (e_cp == e_nl) ? 2'd0 : e_cp + 2'd1;
      e_mask = '0;
      push(1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 1);
      wf(0, 4'd0, 0);
   endtask

   task automatic flip(input logic [3:0] idx);
      e_pd = idx; e_mask[idx] = 1'b1;
      push(1, 0, 2'd0, 1, idx, 0, 0, 1, 0, 0, 0, 1);
   endtask

   // Mismatch: COMPARE, two CMP_WAIT, four REVEAL, NEXT_TURN, WAIT_FLIP.
   task automatic miss(input logic [3:0] idx);
      flip(idx);
      repeat (6) busy_cyc(0);
      next_turn();
   endtask

   // Match: go only on the sampling cycle, W only on the CHECK_WIN cycle.
   task automatic hit(input logic [3:0] idx, input logic w, input logic noise);
      flip(idx);
      busy_cyc(noise);
      busy_cyc(noise);
      push(1, 0, 2'd0, 0, 4'd0, 1, 0, 0, 1, 0, 0, 1);
      busy_cyc(0);
      if (w) begin
         e_gov = 1'b1; e_win = e_cp;
         push(1, 0, 2'd0, 0, 4'd0, 0, 1, 0, 0, 0, 0, 0);
      end else if (e_mask == 16'h0FFF) begin
         e_mask = '0;
         e_cp   = (e_cp == e_nl) ? 2'd0 : e_cp + 2'd1;
         push(1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 1);
         wf(0, 4'd0, 0);
      end else begin
         wf(0, 4'd0, 0);
      end
   endtask

   task automatic check(input string nm, input logic [29:0] got, input logic [29:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; N = '0; flip_valid = 1'b0; flip_idx = '0; go = 1'b0; W = 1'b0;

      do_reset();
      do_start(2'd2);
      hit(4'd5, 0, 0);                 // player 0 matches, keeps the turn
      push(1, 1, 2'd1, 1, 4'd5, 0, 0, 0, 0, 0, 1, 0); // re-flip 5 (and stray start): error only
      wf(0, 4'd0, 0);
      miss(4'd3);                      // player 0 -> 1
      miss(4'd0);                      // player 1 -> 2
      wf(1, 4'd12, 1);                 // first out-of-range index
      wf(1, 4'd13, 1);
      repeat (5) wf(0, 4'd0, 0);
      next_turn();                     // timeout, player 2 wraps to 0
      miss(4'd11);                     // highest valid card, player 0 -> 1
      hit(4'd4, 1, 0);                 // player 1 wins
      push(1, 0, 2'd3, 1, 4'd2, 0, 0, 0, 0, 0, 0, 0); // flips ignored in GAME_OVER
      do_start(2'd0);
      miss(4'd1);                      // single player stays 0
      flip(4'd2);                      // reset lands mid-REVEAL
      repeat (4) busy_cyc(0);
      do_reset();
      wf(1, 4'd3, 0);                  // IDLE ignores flips
      do_start(2'd1);
      for (int i = 0; i < 12; i++) hit(4'(i), 0, i == 0); // board fills -> turn passes

      for (int i = 0; i < vq.size(); i++) begin
         rst = vq[i].rst; start = vq[i].start; N = vq[i].n;
         flip_valid = vq[i].fv; flip_idx = vq[i].fi; go = vq[i].go; W = vq[i].w;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i),
               {position_data, A, B, statecombo_next_turn, cur_player, reveal_mask,
                flip_err, busy, game_over, winner},
               vq[i].exp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
